// File: rtl/ex_arbiter.sv
// Two-port arbiter sharing one ALU/comparator; round-robin or port-0 fixed priority, result registered 1 cycle after grant.
// A port whose single response slot is full and not being drained is not granted; the other port is unaffected.
module ex_arbiter #(
    parameter int FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    input  logic [2:0]  req_op_0,
    input  logic [2:0]  req_op_1,
    input  logic        req_unsig_0,
    input  logic        req_unsig_1,
    input  logic        req_cmp_0,
    input  logic        req_cmp_1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_unsig,
    input  logic [31:0] alu_result,
    input  logic [1:0]  comp_result,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    output logic [31:0] rsp_data_0,
    output logic [31:0] rsp_data_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [15:0] conflict_cnt
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        unsig;
        logic        cmp;
    } req_t;

    req_t        req_0, req_1, req_sel;
    logic        elig_0, elig_1, gnt_0, gnt_1;
    logic [31:0] res;

    logic        rsp_valid_0_q, rsp_valid_0_d;
    logic        rsp_valid_1_q, rsp_valid_1_d;
    logic [31:0] rsp_data_0_q, rsp_data_0_d;
    logic [31:0] rsp_data_1_q, rsp_data_1_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    assign req_0 = {req_a_0, req_b_0, req_op_0, req_unsig_0, req_cmp_0};
    assign req_1 = {req_a_1, req_b_1, req_op_1, req_unsig_1, req_cmp_1};

    always_comb begin
        // A full slot can still accept a new result if it is being drained this cycle.
        elig_0 = req_valid_0 & (~rsp_valid_0_q | rsp_ready_0);
        elig_1 = req_valid_1 & (~rsp_valid_1_q | rsp_ready_1);
        gnt_0  = 1'b0;
        gnt_1  = 1'b0;
        if (elig_0 && elig_1) begin
            if (FIXED_PRI != 0 || last_grant_q) gnt_0 = 1'b1;
            else                                gnt_1 = 1'b1;
        end else begin
            gnt_0 = elig_0;
            gnt_1 = elig_1;
        end
        // Reset is asynchronous, so the combinational grant must be blocked too.
        gnt_0 = gnt_0 & rst_n;
        gnt_1 = gnt_1 & rst_n;

        req_sel = '0;
        if (gnt_1)      req_sel = req_1;
        else if (gnt_0) req_sel = req_0;

        res = req_sel.cmp ? {30'd0, comp_result} : alu_result;

        rsp_valid_0_d = gnt_0 ? 1'b1 : (rsp_ready_0 ? 1'b0 : rsp_valid_0_q);
        rsp_valid_1_d = gnt_1 ? 1'b1 : (rsp_ready_1 ? 1'b0 : rsp_valid_1_q);
        rsp_data_0_d  = gnt_0 ? res : rsp_data_0_q;
        rsp_data_1_d  = gnt_1 ? res : rsp_data_1_q;

        last_grant_d = last_grant_q;
        if (gnt_1)      last_grant_d = 1'b1;
        else if (gnt_0) last_grant_d = 1'b0;

        conflict_cnt_d = conflict_cnt_q;
        if (elig_0 && elig_1 && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_0_q  <= 1'b0;
            rsp_valid_1_q  <= 1'b0;
            rsp_data_0_q   <= 32'd0;
            rsp_data_1_q   <= 32'd0;
            last_grant_q   <= 1'b1;
            conflict_cnt_q <= 16'd0;
        end else begin
            rsp_valid_0_q  <= rsp_valid_0_d;
            rsp_valid_1_q  <= rsp_valid_1_d;
            rsp_data_0_q   <= rsp_data_0_d;
            rsp_data_1_q   <= rsp_data_1_d;
            last_grant_q   <= last_grant_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req_ready_0  = gnt_0;
    assign req_ready_1  = gnt_1;
    assign alu_a        = req_sel.a;
    assign alu_b        = req_sel.b;
    assign alu_op       = req_sel.op;
    assign alu_unsig    = req_sel.unsig;
    assign rsp_valid_0  = rsp_valid_0_q;
    assign rsp_valid_1  = rsp_valid_1_q;
    assign rsp_data_0   = rsp_data_0_q;
    assign rsp_data_1   = rsp_data_1_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/ex_arbiter.md
EX_ARBITER -- requirements
Module: ex_arbiter

Interface
REQ-001 Parameter FIXED_PRI, default 0; 0 = round-robin between ports, 1 = port 0 always wins a conflict.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid_0 / req_valid_1  input  1 each  operation request per port (port 0 = pipeline, port 1 = auxiliary).
REQ-005 req_ready_0 / req_ready_1  output  1 each  request accepted this cycle when high with req_valid.
REQ-006 req_a_0/1, req_b_0/1  input  32 each  operands, already muxed by requester.
REQ-007 req_op_0/1  input  3 each  op_type for ALU; req_unsig_0/1  input  1 each  signed/unsigned select.
REQ-008 req_cmp_0/1  input  1 each  0 = return ALU result, 1 = return comparator result.
REQ-009 alu_a, alu_b  output  32 each; alu_op  output  3; alu_unsig  output  1  drive the shared ALU and COMP.
REQ-010 alu_result  input  32; comp_result  input  2  combinational results from shared ALU/COMP.
REQ-011 rsp_valid_0/1  output  1 each; rsp_data_0/1  output  32 each; rsp_ready_0/1  input  1 each  per-port response handshake.
REQ-012 conflict_cnt  output  16  saturating count of cycles with both ports eligible.

Function
REQ-013 eligible_i SHALL equal req_valid_i AND (NOT rsp_valid_i OR rsp_ready_i).
REQ-014 At most one grant per cycle; single eligible port is granted.
REQ-015 Both eligible, FIXED_PRI=0: grant port NOT equal to last_grant; FIXED_PRI=1: grant port 0.
REQ-016 last_grant register SHALL update to the granted port on every grant; unchanged when no grant.
REQ-017 req_ready_i SHALL equal grant_i (combinational; depends on valid, valid never on ready).
REQ-018 Shared outputs alu_a/alu_b/alu_op/alu_unsig SHALL be combinationally muxed from the granted port; all zero when no grant.
REQ-019 On grant to port i, next edge: rsp_valid_i <= 1, rsp_data_i <= alu_result if req_cmp_i=0, else {30'd0, comp_result}.
REQ-020 Latency: request accepted in cycle N -> rsp_valid_i high in cycle N+1; throughput one op per cycle total.
REQ-021 rsp_valid_i AND rsp_ready_i with no new grant to i: rsp_valid_i <= 0, rsp_data_i holds value.
REQ-022 Response consumed and new grant to same port in the same cycle: rsp_valid_i stays 1, rsp_data_i takes new result (back-to-back, no bubble).
REQ-023 rsp_valid_i high and rsp_ready_i low: port i not eligible; rsp_data_i and rsp_valid_i SHALL hold stable; other port unaffected.
REQ-024 conflict_cnt SHALL increment by 1 each cycle both ports eligible, saturate at 16'hFFFF, never wrap.
REQ-025 Per-port response path SHALL be one entry deep; no further buffering or reordering.

Reset
REQ-026 rst_n low SHALL asynchronously force rsp_valid_0/1=0, rsp_data_0/1=0, last_grant=1, conflict_cnt=0.
REQ-027 During reset req_ready_0/1=0 and shared ALU outputs zero regardless of req_valid.
REQ-028 Reset asserted mid-operation SHALL discard any pending response; first cycle after release behaves as after power-up (port 0 wins first conflict).

Verification
REQ-029 Single op: port 0 valid, a=5, b=7, op=ADD, cmp=0 -> req_ready_0=1 cycle N, rsp_valid_0=1, rsp_data_0=12 cycle N+1.
REQ-030 Conflict RR: both valid continuously, rsp_ready both 1, FIXED_PRI=0 -> grants 0,1,0,1...; conflict_cnt counts every cycle.
REQ-031 Fixed priority: FIXED_PRI=1, both valid 4 cycles -> port 0 granted all 4, port 1 ready 0 throughout.
REQ-032 Back-pressure: port 1 response pending, rsp_ready_1=0 for 3 cycles, port 1 valid -> no grant to port 1, rsp_data_1 stable; port 0 served normally.
REQ-033 Compare mode: port 1, a=32'hFFFF_FFFF, b=1, unsig=0, cmp=1 -> rsp_data_1={30'd0, comp_result} with comp_result[0]=1 (signed less-than).
REQ-034 Saturation and reset: force conflict_cnt to 16'hFFFE, two conflict cycles -> 16'hFFFF held; assert rst_n low mid-response -> rsp_valid 0 immediately, counter 0.
